// File: rtl/servo_pulse_decoder_pkg.sv
// Shared servo timing definitions and decoder state encoding.
// Used by both the pulse decoder and the pulse generator side.
package servo_pulse_decoder_pkg;

  localparam int CLK_HZ           = 50_000_000;
  localparam int US_PER_TICK      = 1;
  localparam int CLK_DIV_DEF      = (CLK_HZ / 1_000_000) * US_PER_TICK;
  localparam int SERVO_MIN_US     = 500;
  localparam int SERVO_MAX_US     = 2500;
  localparam int SERVO_CENTER_US  = 1500;
  localparam int SERVO_STUCK_US   = 4000;
  localparam int SERVO_TIMEOUT_US = 25000;
  localparam int US_W             = 16;

  typedef enum logic [1:0] {
    SYNC_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } dec_state_t;

  function automatic logic out_of_range(input logic [US_W-1:0] width,
                                        input int min_us,
                                        input int max_us);
    int w;
    w = int'(width);
    return (w < min_us) || (w > max_us);
  endfunction

endpackage

// File: rtl/servo_pulse_decoder_us_tick_gen.sv
// Restartable 1 us prescaler: counts 0..CLK_DIV-1 and fires tick on the last count.
// restart zeroes the count so tick phase can be locked to an external event.
module us_tick_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A restart cycle never counts as a tick; the new period starts next cycle.
  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo PWM receiver: measures pulse high time in us, flags out-of-range and stuck pulses,
// and reports loss of signal when rising edges stop arriving.
//
// state     | meaning
// SYNC_LOW  | wait for the synced input to be low before arming (discards partial pulses)
// WAIT_RISE | armed, waiting for a rising edge
// MEASURE   | pulse high, counting us ticks into hi_cnt
module servo_pulse_decoder
  import servo_pulse_decoder_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int MIN_US     = SERVO_MIN_US,
  parameter int MAX_US     = SERVO_MAX_US,
  parameter int STUCK_US   = SERVO_STUCK_US,
  parameter int TIMEOUT_US = SERVO_TIMEOUT_US
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pwm_in,
  output logic [US_W-1:0] width_us,
  output logic            width_valid,
  output logic            range_err,
  output logic            signal_lost
);

  localparam logic [US_W-1:0] STUCK_CNT   = US_W'(STUCK_US);
  localparam logic [US_W-1:0] TIMEOUT_CNT = US_W'(TIMEOUT_US);

  logic            sync1, sync2, edge_q;
  logic            rise, fall, tick;
  dec_state_t      state_q, state_d;
  logic            start_meas, load_width, abort;
  logic [US_W-1:0] hi_cnt, hi_next, gap_cnt;
  logic            stuck, next_oor;

  // Synchronizer resets high so a pin already high at reset release is never seen as a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      edge_q <= 1'b1;
    end else begin
      sync1  <= pwm_in;
      sync2  <= sync1;
      edge_q <= sync2;
    end
  end

  assign rise = sync2 & ~edge_q;
  assign fall = ~sync2 & edge_q;

  us_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (rise),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SYNC_LOW;
    end else begin
      state_q <= state_d;
    end
  end

  assign stuck = (hi_cnt == STUCK_CNT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC_LOW:  if (!sync2) state_d = WAIT_RISE;
      WAIT_RISE: if (rise)   state_d = MEASURE;
      MEASURE: begin
        if (fall)       state_d = WAIT_RISE;
        else if (stuck) state_d = SYNC_LOW;
      end
      default:          state_d = SYNC_LOW;
    endcase
  end

  always_comb begin
    start_meas = 1'b0;
    load_width = 1'b0;
    abort      = 1'b0;
    case (state_q)
      WAIT_RISE: start_meas = rise;
      MEASURE: begin
        load_width = fall;
        abort      = !fall && stuck;
      end
      default: ;
    endcase
  end

  // A tick landing in the fall cycle is included in the reported width.
  assign hi_next  = tick ? (hi_cnt + US_W'(1)) : hi_cnt;
  assign next_oor = out_of_range(hi_next, MIN_US, MAX_US);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_cnt <= '0;
    end else if (start_meas) begin
      hi_cnt <= '0;
    end else if (state_q == MEASURE) begin
      hi_cnt <= hi_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (rise) begin
      gap_cnt <= '0;
    end else if (tick && (gap_cnt != TIMEOUT_CNT)) begin
      gap_cnt <= gap_cnt + US_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_us    <= '0;
      width_valid <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      width_valid <= load_width;
      if (load_width) begin
        width_us  <= hi_next;
        range_err <= next_oor;
      end else if (abort) begin
        range_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signal_lost <= 1'b1;
    end else if (load_width && !next_oor) begin
      signal_lost <= 1'b0;
    end else if (gap_cnt == TIMEOUT_CNT) begin
      signal_lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder, run with a scaled-down tick (4 clk per us)
// and scaled us limits so each scenario stays short.
module tb_servo_pulse_decoder;

  localparam int CLK_DIV    = 4;
  localparam int MIN_US     = 50;
  localparam int MAX_US     = 250;
  localparam int STUCK_US   = 400;
  localparam int TIMEOUT_US = 2500;

  logic        clk = 1'b0;
  logic        reset;
  logic        pwm_in;
  logic [15:0] width_us;
  logic        width_valid;
  logic        range_err;
  logic        signal_lost;

  int errors  = 0;
  int checks  = 0;
  int strobes = 0;
  int s0;

  always #10 clk = ~clk;

  servo_pulse_decoder #(
    .CLK_DIV    (CLK_DIV),
    .MIN_US     (MIN_US),
    .MAX_US     (MAX_US),
    .STUCK_US   (STUCK_US),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .width_us    (width_us),
    .width_valid (width_valid),
    .range_err   (range_err),
    .signal_lost (signal_lost)
  );

  always @(posedge clk) begin
    #1;
    if (width_valid) strobes++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic meas(input string tag, input int hi, input int exp_w, input int exp_err);
    int s;
    s = strobes;
    hold(1'b1, hi);
    hold(1'b0, 1000);
    chk({tag, "_strobes"}, strobes - s, 1);
    chk({tag, "_width"}, int'(width_us), exp_w);
    chk({tag, "_err"}, int'(range_err), exp_err);
  endtask

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_width", int'(width_us), 0);
    chk("rst_valid", int'(width_valid), 0);
    chk("rst_err", int'(range_err), 0);
    chk("rst_lost", int'(signal_lost), 1);
    reset = 1'b0;
    hold(1'b0, 20);

    // Nominal 150 us pulse with exact strobe latency.
    s0 = strobes;
    hold(1'b1, 600);
    pwm_in = 1'b0;
    @(negedge clk); chk("t1_lat1", int'(width_valid), 0);
    @(negedge clk); chk("t1_lat2", int'(width_valid), 0);
    @(negedge clk); chk("t1_lat3", int'(width_valid), 1);
    chk("t1_width", int'(width_us), 150);
    chk("t1_err", int'(range_err), 0);
    chk("t1_lost", int'(signal_lost), 0);
    @(negedge clk); chk("t1_lat4", int'(width_valid), 0);
    hold(1'b0, 7396);
    chk("t1_strobes", strobes - s0, 1);

    meas("floor603", 603, 150, 0);
    meas("short30", 120, 30, 1);
    chk("short30_lost", int'(signal_lost), 0);
    meas("min50", 200, 50, 0);
    meas("min49", 199, 49, 1);
    meas("max250", 1003, 250, 0);
    meas("max251", 1004, 251, 1);

    // Stuck-high pulse aborts without a strobe.
    meas("pre_abort", 800, 200, 0);
    s0 = strobes;
    hold(1'b1, 2000);
    chk("abort_err", int'(range_err), 1);
    chk("abort_width", int'(width_us), 200);
    hold(1'b0, 1000);
    chk("abort_strobes", strobes - s0, 0);
    meas("post_abort", 480, 120, 0);

    // Signal loss after a long low gap.
    s0 = strobes;
    hold(1'b1, 600);
    hold(1'b0, 9380);
    chk("loss_pre", int'(signal_lost), 0);
    chk("loss_pre_width", int'(width_us), 150);
    hold(1'b0, 100);
    chk("loss_set", int'(signal_lost), 1);
    chk("loss_strobes", strobes - s0, 1);
    meas("loss_bad", 120, 30, 1);
    chk("loss_bad_lost", int'(signal_lost), 1);
    meas("loss_good", 600, 150, 0);
    chk("loss_clear", int'(signal_lost), 0);

    // Reset asserted mid-pulse.
    hold(1'b1, 300);
    reset = 1'b1;
    #1;
    chk("mid_rst_width", int'(width_us), 0);
    chk("mid_rst_valid", int'(width_valid), 0);
    chk("mid_rst_err", int'(range_err), 0);
    chk("mid_rst_lost", int'(signal_lost), 1);
    hold(1'b1, 3);
    reset = 1'b0;
    s0 = strobes;
    hold(1'b1, 300);
    hold(1'b0, 1000);
    chk("mid_rst_strobes", strobes - s0, 0);
    meas("mid_rst_next", 720, 180, 0);

    // Pin already high when reset deasserts.
    reset  = 1'b1;
    pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    s0 = strobes;
    hold(1'b1, 4000);
    hold(1'b0, 1000);
    chk("partial_strobes", strobes - s0, 0);
    chk("partial_width", int'(width_us), 0);
    meas("partial_next", 800, 200, 0);
    chk("partial_lost", int'(signal_lost), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
